branch_resolve_queue: RTL and testbench
=======================================

// Module: branch_resolve_queue
// PURPOSE
//  Downstream partner of the fetch-stage branch predictor. Holds in-order in-flight branch predictions from fetch,
//  retires them against execute outcomes, and returns the training update (v/branch/branch_id) to the predictor.
//  On a mispredict, pulses flush with the corrected PC and discards all younger entries. Also drives the fetch full/stall.
// PARAMETERS
//  DEPTH   4   entries in flight; power of two, >= 2
//  W_PTR   2   log2(DEPTH)
//  W_ADDR  16  PC width; taken from params.v
//  W_BRID  2   predictor counter width; taken from params.v
// PORTS
//  clk             in   1        clock; single clock domain, all state on posedge
//  reset           in   1        synchronous, active-low reset
//  push_v_i        in   1        fetch issues a predicted branch this cycle
//  push_pred_i     in   1        predicted direction (1 = taken)
//  push_pred_id_i  in   W_BRID   counter snapshot at prediction time
//  push_target_i   in   W_ADDR   taken-path PC
//  push_fall_i     in   W_ADDR   not-taken-path PC
//  full_o          in/out -> out 1  queue full; fetch must stall (comb from count)
//  empty_o         out  1        no entries (comb from count)
//  count_o         out  W_PTR+1  occupancy 0..DEPTH
//  res_v_i         in   1        execute resolves the oldest branch
//  res_taken_i     in   1        actual direction
//  upd_v_o         out  1        registered; drives predictor v_i
//  upd_branch_o    out  1        registered actual direction; drives predictor branch_i
//  upd_branch_id_o out  W_BRID   registered snapshot of the resolved entry; drives predictor branch_id_i
//  flush_o         out  1        registered one-cycle mispredict pulse
//  redirect_o      out  W_ADDR   registered corrected PC; valid when flush_o=1, otherwise holds last value
//  err_o           out  1        sticky: res_v_i seen while empty; cleared only by reset
// BEHAVIOUR
//  Reset (reset==0 at posedge): rd/wr ptr=0, count=0, state=RUN, all registered outputs 0. Asserting reset mid-flight drops every entry.
//  Entry = {pred, pred_id, target, fall}. Storage is a register array with no reset requirement.
//  Pointers wrap modulo DEPTH. count is W_PTR+1 bits; full = (count==DEPTH), empty = (count==0).
//  pop = res_v_i & ~empty. Resolution while empty: ignored; err_o set to 1.
//  push accepted = push_v_i & state==RUN & (~full | pop) & ~mis. Push while full with no pop: dropped, because fetch must honour full_o.
//  Simultaneous push and pop: both take effect and count is unchanged; a push into a full queue is legal when a pop occurs in the same cycle.
//  mis = pop & (head.pred != res_taken_i).
//  Latency: 1 cycle from res_v_i to upd_*/flush_o.
//  On every pop: upd_v_o=1, upd_branch_o=res_taken_i, upd_branch_id_o=head.pred_id. Otherwise upd_v_o=0 and the data outputs hold.
//  On mis: flush_o=1; redirect_o = res_taken_i ? head.target : head.fall. Remaining entries are wrong-path, so rd=wr=0, count=0, state->FLUSH. A same-cycle push is dropped.
//  FSM: RUN --mis--> FLUSH; FLUSH --(1 cycle)--> RUN.
//   In FLUSH, pushes are ignored while fetch redirects. res_v_i is ignored with no err_o, because the queue is empty by design.
//  A correct prediction performs no flush; the next head becomes visible the following cycle.
// STRUCTURE
//  params.v (shared include): W_BRID, W_ADDR, BRQ_DEPTH, BRQ_W_PTR, and the state encodings S_RUN=1'b0, S_FLUSH=1'b1.
//  One natural sub-module: brq_fifo, holding storage, pointers, count, full/empty, and a sync clear input.
//  The top level holds the compare, FSM, and output registers.
// TESTING
//  1. Reset: hold reset=0 for 2 cycles -> count_o=0, empty_o=1, upd_v_o=0, flush_o=0, err_o=0.
//  2. Correct prediction: push {pred=1, id=2'b11, tgt=16'h0040, fall=16'h0004}; next cycle res_v_i=1, taken=1
//     -> following cycle upd_v_o=1, upd_branch_o=1, upd_branch_id_o=2'b11, flush_o=0, count_o=0.
//  3. Fill and overlap: 4 pushes -> full_o=1. A 5th push with no pop is dropped and count stays 4.
//     Push together with a correct resolve -> count stays 4, and the FIFO order is preserved across pointer wrap.
//  4. Mispredict flush: 3 entries, head {pred=1, fall=16'h0010}; resolve with taken=0 and a simultaneous push
//     -> flush_o=1 for exactly 1 cycle, redirect_o=16'h0010, upd_branch_o=0, count_o=0.
//     A push in the FLUSH cycle is ignored; the next cycle's push is accepted.
//  5. Empty resolve: res_v_i=1 with empty queue in RUN -> upd_v_o=0 and err_o=1, which stays 1 until reset.
//  6. Reset mid-operation: 2 entries, then reset=0 for 1 cycle coincident with res_v_i
//     -> no upd_v_o/flush_o, count_o=0, state RUN.

Source files
------------

// File: rtl/branch_resolve_queue_pkg.sv
// Shared sizing and state encodings for the branch resolve queue and its FIFO.
package branch_resolve_queue_pkg;

    localparam int unsigned BRQ_DEPTH = 4;
    localparam int unsigned BRQ_W_PTR = 2;
    localparam int unsigned W_ADDR    = 16;
    localparam int unsigned W_BRID    = 2;

    typedef enum logic {
        StRun   = 1'b0,
        StFlush = 1'b1
    } brq_state_e;

endpackage

// File: rtl/branch_resolve_queue_fifo.sv
// In-order storage for in-flight branch entries: pointers, occupancy and a synchronous clear.
module branch_resolve_queue_fifo #(
    parameter int unsigned Depth = 4,
    parameter int unsigned PtrW  = 2,
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [Width-1:0] wdata_i,
    output logic [Width-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [PtrW:0]    count_o
);

    logic [Width-1:0] mem_q [Depth];
    logic [Width-1:0] mem_d [Depth];
    logic [PtrW-1:0]  wr_q, wr_d, rd_q, rd_d;
    logic [PtrW:0]    count_q, count_d;

    assign rdata_o = mem_q[rd_q];
    assign full_o  = (count_q == (PtrW+1)'(Depth));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

    always_comb begin
        mem_d   = mem_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        if (push_i) begin
            mem_d[wr_q] = wdata_i;
        end
        if (clr_i) begin
            wr_d    = '0;
            rd_d    = '0;
            count_d = '0;
        end else begin
            if (push_i) wr_d = wr_q + PtrW'(1);
            if (pop_i)  rd_d = rd_q + PtrW'(1);
            unique case ({push_i, pop_i})
                2'b10:   count_d = count_q + (PtrW+1)'(1);
                2'b01:   count_d = count_q - (PtrW+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

    // Entry storage carries no reset; occupancy alone says what is valid.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/branch_resolve_queue.sv
// Retires in-order branch predictions against execute outcomes, trains the predictor,
// and flushes with the corrected PC on a mispredict.
module branch_resolve_queue
    import branch_resolve_queue_pkg::*;
#(
    parameter int unsigned DEPTH  = BRQ_DEPTH,
    parameter int unsigned W_PTR  = BRQ_W_PTR,
    parameter int unsigned W_ADDR = branch_resolve_queue_pkg::W_ADDR,
    parameter int unsigned W_BRID = branch_resolve_queue_pkg::W_BRID
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push_v_i,
    input  logic              push_pred_i,
    input  logic [W_BRID-1:0] push_pred_id_i,
    input  logic [W_ADDR-1:0] push_target_i,
    input  logic [W_ADDR-1:0] push_fall_i,
    output logic              full_o,
    output logic              empty_o,
    output logic [W_PTR:0]    count_o,
    input  logic              res_v_i,
    input  logic              res_taken_i,
    output logic              upd_v_o,
    output logic              upd_branch_o,
    output logic [W_BRID-1:0] upd_branch_id_o,
    output logic              flush_o,
    output logic [W_ADDR-1:0] redirect_o,
    output logic              err_o
);

    localparam int unsigned EntryW = 1 + W_BRID + 2 * W_ADDR;

    brq_state_e        state_q, state_d;
    logic              upd_v_q, upd_v_d;
    logic              upd_branch_q, upd_branch_d;
    logic [W_BRID-1:0] upd_id_q, upd_id_d;
    logic              flush_q, flush_d;
    logic [W_ADDR-1:0] redirect_q, redirect_d;
    logic              err_q, err_d;

    logic [EntryW-1:0] head;
    logic              head_pred;
    logic [W_BRID-1:0] head_id;
    logic [W_ADDR-1:0] head_tgt, head_fall;
    logic              fifo_full, fifo_empty;
    logic              run, pop, mis, push;

    assign head_pred = head[EntryW-1];
    assign head_id   = head[2*W_ADDR +: W_BRID];
    assign head_tgt  = head[W_ADDR +: W_ADDR];
    assign head_fall = head[W_ADDR-1:0];

    assign run  = (state_q == StRun);
    assign pop  = res_v_i & ~fifo_empty;
    assign mis  = pop & (head_pred != res_taken_i);
    // A full queue still accepts a push when the head retires in the same cycle.
    assign push = push_v_i & run & (~fifo_full | pop) & ~mis;

    branch_resolve_queue_fifo #(
        .Depth (DEPTH),
        .PtrW  (W_PTR),
        .Width (EntryW)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (reset),
        .clr_i   (mis),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i ({push_pred_i, push_pred_id_i, push_target_i, push_fall_i}),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (count_o)
    );

    always_comb begin
        state_d      = state_q;
        upd_v_d      = pop;
        upd_branch_d = upd_branch_q;
        upd_id_d     = upd_id_q;
        flush_d      = mis;
        redirect_d   = redirect_q;
        // In FLUSH the queue is empty by design, so a stray resolve is not an error.
        err_d        = err_q | (res_v_i & fifo_empty & run);
        if (pop) begin
            upd_branch_d = res_taken_i;
            upd_id_d     = head_id;
        end
        if (mis) begin
            redirect_d = res_taken_i ? head_tgt : head_fall;
        end
        unique case (state_q)
            StRun:   if (mis) state_d = StFlush;
            StFlush: state_d = StRun;
            default: state_d = StRun;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= StRun;
            upd_v_q      <= 1'b0;
            upd_branch_q <= 1'b0;
            upd_id_q     <= '0;
            flush_q      <= 1'b0;
            redirect_q   <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            upd_v_q      <= upd_v_d;
            upd_branch_q <= upd_branch_d;
            upd_id_q     <= upd_id_d;
            flush_q      <= flush_d;
            redirect_q   <= redirect_d;
            err_q        <= err_d;
        end
    end

    assign full_o          = fifo_full;
    assign empty_o         = fifo_empty;
    assign upd_v_o         = upd_v_q;
    assign upd_branch_o    = upd_branch_q;
    assign upd_branch_id_o = upd_id_q;
    assign flush_o         = flush_q;
    assign redirect_o      = redirect_q;
    assign err_o           = err_q;

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Directed bench: the driver queues expected training updates, a negedge monitor checks them.
module tb_branch_resolve_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic        push_v_i, push_pred_i;
    logic [1:0]  push_pred_id_i;
    logic [15:0] push_target_i, push_fall_i;
    logic        full_o, empty_o;
    logic [2:0]  count_o;
    logic        res_v_i, res_taken_i;
    logic        upd_v_o, upd_branch_o;
    logic [1:0]  upd_branch_id_o;
    logic        flush_o;
    logic [15:0] redirect_o;
    logic        err_o;

    typedef struct packed {
        logic        br;
        logic [1:0]  id;
        logic        fl;
        logic [15:0] rd;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    branch_resolve_queue dut (
        .clk             (clk),
        .reset           (reset),
        .push_v_i        (push_v_i),
        .push_pred_i     (push_pred_i),
        .push_pred_id_i  (push_pred_id_i),
        .push_target_i   (push_target_i),
        .push_fall_i     (push_fall_i),
        .full_o          (full_o),
        .empty_o         (empty_o),
        .count_o         (count_o),
        .res_v_i         (res_v_i),
        .res_taken_i     (res_taken_i),
        .upd_v_o         (upd_v_o),
        .upd_branch_o    (upd_branch_o),
        .upd_branch_id_o (upd_branch_id_o),
        .flush_o         (flush_o),
        .redirect_o      (redirect_o),
        .err_o           (err_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h, want %0h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic pv, input logic pp, input logic [1:0] pid,
                         input logic [15:0] tgt, input logic [15:0] fall,
                         input logic rv, input logic tk);
        push_v_i       = pv;
        push_pred_i    = pp;
        push_pred_id_i = pid;
        push_target_i  = tgt;
        push_fall_i    = fall;
        res_v_i        = rv;
        res_taken_i    = tk;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 2'b00, 16'h0, 16'h0, 1'b0, 1'b0);
    endtask

    task automatic expect_upd(input logic br, input logic [1:0] id, input logic fl,
                              input logic [15:0] rd);
        exp_t e;
        e.br = br;
        e.id = id;
        e.fl = fl;
        e.rd = rd;
        exp_q.push_back(e);
    endtask

    // Monitor: every update or flush the DUT presents must match the oldest expectation.
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            if (upd_v_o === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_upd: got upd_v_o=1, want 0");
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("upd_branch", 32'(upd_branch_o), 32'(e.br));
                    chk("upd_branch_id", 32'(upd_branch_id_o), 32'(e.id));
                    chk("upd_flush", 32'(flush_o), 32'(e.fl));
                    if (e.fl) chk("redirect", 32'(redirect_o), 32'(e.rd));
                end
            end else if (flush_o === 1'b1) begin
                checks++;
                failures++;
                $display("FAIL stray_flush: got flush_o=1 without upd_v_o, want 0");
            end
        end
    end

    initial begin
        reset = 1'b0;
        idle();
        // Reset
        step();
        step();
        chk("rst_count", 32'(count_o), 32'd0);
        chk("rst_empty", 32'(empty_o), 32'd1);
        chk("rst_upd_v", 32'(upd_v_o), 32'd0);
        chk("rst_flush", 32'(flush_o), 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        reset = 1'b1;
        step();

        // Correct prediction
        drive(1'b1, 1'b1, 2'b11, 16'h0040, 16'h0004, 1'b0, 1'b0);
        step();
        chk("t2_count1", 32'(count_o), 32'd1);
        drive(1'b0, 1'b0, 2'b00, 16'h0, 16'h0, 1'b1, 1'b1);
        expect_upd(1'b1, 2'b11, 1'b0, 16'h0);
        step();
        idle();
        chk("t2_count0", 32'(count_o), 32'd0);
        chk("t2_upd_v", 32'(upd_v_o), 32'd1);
        step();

        // Fill, overflow drop, push with pop across the pointer wrap
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, 2'(i), 16'h0100 + 16'(i), 16'h0200 + 16'(i), 1'b0, 1'b0);
            step();
        end
        chk("t3_full", 32'(full_o), 32'd1);
        chk("t3_count4", 32'(count_o), 32'd4);
        drive(1'b1, 1'b0, 2'b10, 16'h0BAD, 16'h0BAD, 1'b0, 1'b0);
        step();
        chk("t3_drop_count", 32'(count_o), 32'd4);
        drive(1'b1, 1'b0, 2'b01, 16'h0300, 16'h0301, 1'b1, 1'b1);
        expect_upd(1'b1, 2'd0, 1'b0, 16'h0);
        step();
        chk("t3_overlap_count", 32'(count_o), 32'd4);
        for (int i = 1; i < 4; i++) begin
            drive(1'b0, 1'b0, 2'b00, 16'h0, 16'h0, 1'b1, 1'b1);
            expect_upd(1'b1, 2'(i), 1'b0, 16'h0);
            step();
        end
        drive(1'b0, 1'b0, 2'b00, 16'h0, 16'h0, 1'b1, 1'b0);
        expect_upd(1'b0, 2'b01, 1'b0, 16'h0);
        step();
        idle();
        chk("t3_drained", 32'(count_o), 32'd0);
        chk("t3_err", 32'(err_o), 32'd0);
        step();

        // Mispredict flush
        drive(1'b1, 1'b1, 2'b10, 16'h0020, 16'h0010, 1'b0, 1'b0);
        step();
        drive(1'b1, 1'b0, 2'b01, 16'h0030, 16'h0031, 1'b0, 1'b0);
        step();
        drive(1'b1, 1'b1, 2'b00, 16'h0040, 16'h0041, 1'b0, 1'b0);
        step();
        chk("t4_count3", 32'(count_o), 32'd3);
        drive(1'b1, 1'b1, 2'b11, 16'h0050, 16'h0051, 1'b1, 1'b0);
        expect_upd(1'b0, 2'b10, 1'b1, 16'h0010);
        step();
        chk("t4_flush", 32'(flush_o), 32'd1);
        chk("t4_redirect", 32'(redirect_o), 32'h0010);
        chk("t4_count0", 32'(count_o), 32'd0);
        drive(1'b1, 1'b1, 2'b01, 16'h0060, 16'h0061, 1'b1, 1'b1);
        step();
        chk("t4_flush_once", 32'(flush_o), 32'd0);
        chk("t4_flush_push_ign", 32'(count_o), 32'd0);
        chk("t4_flush_no_err", 32'(err_o), 32'd0);
        drive(1'b1, 1'b0, 2'b01, 16'h0070, 16'h0071, 1'b0, 1'b0);
        step();
        chk("t4_push_after", 32'(count_o), 32'd1);
        drive(1'b0, 1'b0, 2'b00, 16'h0, 16'h0, 1'b1, 1'b1);
        expect_upd(1'b1, 2'b01, 1'b1, 16'h0070);
        step();
        chk("t4_redirect2", 32'(redirect_o), 32'h0070);
        idle();
        step();

        // Empty resolve
        drive(1'b0, 1'b0, 2'b00, 16'h0, 16'h0, 1'b1, 1'b1);
        step();
        idle();
        chk("t5_err", 32'(err_o), 32'd1);
        chk("t5_upd_v", 32'(upd_v_o), 32'd0);
        step();
        step();
        chk("t5_err_sticky", 32'(err_o), 32'd1);

        // Reset mid-operation
        drive(1'b1, 1'b1, 2'b01, 16'h0080, 16'h0081, 1'b0, 1'b0);
        step();
        drive(1'b1, 1'b0, 2'b10, 16'h0090, 16'h0091, 1'b0, 1'b0);
        step();
        chk("t6_count2", 32'(count_o), 32'd2);
        reset = 1'b0;
        drive(1'b0, 1'b0, 2'b00, 16'h0, 16'h0, 1'b1, 1'b0);
        step();
        chk("t6_count0", 32'(count_o), 32'd0);
        chk("t6_upd_v", 32'(upd_v_o), 32'd0);
        chk("t6_flush", 32'(flush_o), 32'd0);
        chk("t6_err", 32'(err_o), 32'd0);
        reset = 1'b1;
        drive(1'b1, 1'b0, 2'b10, 16'h00A0, 16'h00A1, 1'b0, 1'b0);
        step();
        chk("t6_run_push", 32'(count_o), 32'd1);
        drive(1'b0, 1'b0, 2'b00, 16'h0, 16'h0, 1'b1, 1'b0);
        expect_upd(1'b0, 2'b10, 1'b0, 16'h0);
        step();
        idle();
        step();
        step();
        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
